// File: rtl/imm_extend_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_unit_if
// Description : Bundles the upstream (immediate offer) and downstream
//               (extended result) handshakes of imm_extend_unit.
//               slave  : the extension unit side
//               master : the producer/consumer side (environment)
// Signals     : in_valid/in_ready   upstream handshake
//               upper/lower         halves of the immediate field (IMM_W/2)
//               mode                00 sext, 01 zext, 10 upper-load, 11 prefix
//               out_valid/out_ready downstream handshake
//               imme                extended result (DATA_W)
//               err                 one-cycle protocol error pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_extend_unit_if #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IMM_W/2-1:0]    upper;
  logic [IMM_W/2-1:0]    lower;
  logic [1:0]            mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     imme;
  logic                  err;

  modport master (
    output in_valid, upper, lower, mode, out_ready,
    input  in_ready, out_valid, imme, err
  );

  modport slave (
    input  in_valid, upper, lower, mode, out_ready,
    output in_ready, out_valid, imme, err
  );
endinterface
`default_nettype wire

// File: rtl/imm_extend_unit.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_unit
// Description : Extends an IMM_W-bit immediate to DATA_W bits (sign-extend,
//               zero-extend or left-justify) through a one-entry registered
//               output stage with valid/ready handshakes on both sides.
//               With IMM_EXTEND_PREFIX_EN defined, mode 11 loads a prefix that
//               widens the next operation's operand to 2*IMM_W bits.
// Ports       : clock  - rising-edge clock
//               reset  - synchronous, active-low reset
//               bus    - imm_extend_unit_if.slave (handshakes, operands,
//                        result, err)
// Config      : IMM_EXTEND_PREFIX_EN - enables the prefix state machine.
//               Undefined: mode 11 behaves as zero-extend and pulses err.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_unit #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8
) (
  input  wire logic          clock,
  input  wire logic          reset,
  imm_extend_unit_if.slave   bus
);

  localparam logic [1:0] c_MODE_SEXT = 2'b00;
  localparam logic [1:0] c_MODE_LJ   = 2'b10;
  localparam logic [1:0] c_MODE_PFX  = 2'b11;

  // --------------------------------------------------------------------------
  // Extension datapath. The operand is always carried 2*IMM_W wide; in the
  // narrow case its upper half is zero and the sign comes from bit IMM_W-1.
  // Shifting the zero-extended value left-justifies it, which also works when
  // DATA_W == 2*IMM_W (zero shift) without zero-width replications.
  // --------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] f_extend(
    input logic [2*IMM_W-1:0] x,
    input logic               wide,
    input logic [1:0]         m
  );
    logic [DATA_W-1:0] zx;
    logic [DATA_W-1:0] sx;
    logic [DATA_W-1:0] lj;
    zx = DATA_W'(x);
    if (wide) begin
      sx = DATA_W'($signed(x));
      lj = zx << (DATA_W - 2*IMM_W);
    end else begin
      sx = DATA_W'($signed(x[IMM_W-1:0]));
      lj = zx << (DATA_W - IMM_W);
    end
    case (m)
      c_MODE_SEXT: f_extend = sx;
      c_MODE_LJ:   f_extend = lj;
      default:     f_extend = zx;
    endcase
  endfunction

  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    imme_q, imme_d;
  logic                 err_q, err_d;

  logic                 w_accept;
  logic                 w_is_pfx_mode;
  logic                 w_load;
  logic [IMM_W-1:0]     w_x_short;
  logic [DATA_W-1:0]    w_result;

  // One-entry output register: a new offer fits if the slot is empty or is
  // being drained in this same cycle.
  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_is_pfx_mode = (bus.mode == c_MODE_PFX);
  assign w_x_short     = {bus.upper, bus.lower};

`ifdef IMM_EXTEND_PREFIX_EN
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IMM_W-1:0]     pfx_q, pfx_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      pfx_q   <= '0;
    end else begin
      state_q <= state_d;
      pfx_q   <= pfx_d;
    end
  end

  // A prefix always (re)arms PENDING; any other accepted op consumes it.
  always_comb begin
    state_d = state_q;
    pfx_d   = pfx_q;
    if (w_accept) begin
      if (w_is_pfx_mode) begin
        state_d = PENDING;
        pfx_d   = w_x_short;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Prefixes produce no result; a second prefix in a row overwrites the
  // first and is flagged.
  assign w_load = w_accept && !w_is_pfx_mode;
  assign err_d  = w_accept && w_is_pfx_mode && (state_q == PENDING);

  always_comb begin
    w_result = '0;
    if (state_q == PENDING) begin
      w_result = f_extend({pfx_q, w_x_short}, 1'b1, bus.mode);
    end else begin
      w_result = f_extend({{IMM_W{1'b0}}, w_x_short}, 1'b0, bus.mode);
    end
  end
`else
  // Without prefix support every accepted op produces a result; mode 11
  // falls through to zero-extend in f_extend and is reported as an error.
  assign w_load = w_accept;
  assign err_d  = w_accept && w_is_pfx_mode;

  always_comb begin
    w_result = '0;
    w_result = f_extend({{IMM_W{1'b0}}, w_x_short}, 1'b0, bus.mode);
  end
`endif

  // Output slot: a load wins over a drain so a simultaneous consume + load
  // keeps out_valid high with the new result.
  always_comb begin
    out_valid_d = out_valid_q;
    imme_d      = imme_q;
    if (w_load) begin
      out_valid_d = 1'b1;
      imme_d      = w_result;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      imme_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      imme_q      <= imme_d;
      err_q       <= err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.imme      = imme_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_unit
// Description : Directed self-checking bench for imm_extend_unit
//               (DATA_W=16, IMM_W=8). Expectations follow the build
//               configuration (IMM_EXTEND_PREFIX_EN defined or not).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  imm_extend_unit_if #(.DATA_W(16), .IMM_W(8)) bus_if ();

  imm_extend_unit #(.DATA_W(16), .IMM_W(8)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  u;
    logic [3:0]  l;
    logic [1:0]  m;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] u, input logic [3:0] l, input logic [1:0] m);
    bus_if.in_valid = v;
    bus_if.upper    = u;
    bus_if.lower    = l;
    bus_if.mode     = m;
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0] = '{4'hF, 4'h6, 2'b00, 16'hFFF6};
    vecs[1] = '{4'hF, 4'h6, 2'b01, 16'h00F6};
    vecs[2] = '{4'hF, 4'h6, 2'b10, 16'hF600};
    vecs[3] = '{4'h7, 4'hF, 2'b00, 16'h007F};
    vecs[4] = '{4'h8, 4'h0, 2'b00, 16'hFF80};
    vecs[5] = '{4'h8, 4'h0, 2'b10, 16'h8000};
    vecs[6] = '{4'h0, 4'h0, 2'b00, 16'h0000};
    vecs[7] = '{4'hF, 4'hF, 2'b01, 16'h00FF};
    vecs[8] = '{4'hA, 4'h5, 2'b10, 16'hA500};
    vecs[9] = '{4'h8, 4'h1, 2'b01, 16'h0081};

    rst_n = 1'b0;
    bus_if.out_ready = 1'b0;
    drive(1'b1, 4'h3, 4'h3, 2'b00);
    step();
    step();
    chk("reset_out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("reset_imme", 32'(bus_if.imme), 32'h0);
    chk("reset_err", 32'(bus_if.err), 32'd0);
    chk("reset_in_ready", 32'(bus_if.in_ready), 32'd1);
    drive(1'b0, 4'h0, 4'h0, 2'b00);
    rst_n = 1'b1;
    step();

    // Table: back-to-back ops with out_ready=1, one result per cycle.
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].u, vecs[i].l, vecs[i].m);
      chk($sformatf("vec%0d_in_ready", i), 32'(bus_if.in_ready), 32'd1);
      step();
      chk($sformatf("vec%0d_out_valid", i), 32'(bus_if.out_valid), 32'd1);
      chk($sformatf("vec%0d_imme", i), 32'(bus_if.imme), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_err", i), 32'(bus_if.err), 32'd0);
    end
    drive(1'b0, 4'h0, 4'h0, 2'b00);
    step();
    chk("drain_out_valid", 32'(bus_if.out_valid), 32'd0);

    // Prefix then sign-extend.
    drive(1'b1, 4'h1, 4'h2, 2'b11);
    step();
`ifdef IMM_EXTEND_PREFIX_EN
    chk("pfx_no_output", 32'(bus_if.out_valid), 32'd0);
    chk("pfx_no_err", 32'(bus_if.err), 32'd0);
`else
    chk("nopfx_first_valid", 32'(bus_if.out_valid), 32'd1);
    chk("nopfx_first_imme", 32'(bus_if.imme), 32'h0012);
    chk("nopfx_first_err", 32'(bus_if.err), 32'd1);
`endif
    drive(1'b1, 4'h3, 4'h4, 2'b00);
    step();
    chk("pfx_op_valid", 32'(bus_if.out_valid), 32'd1);
    chk("pfx_op_err", 32'(bus_if.err), 32'd0);
`ifdef IMM_EXTEND_PREFIX_EN
    chk("pfx_op_imme", 32'(bus_if.imme), 32'h1234);
`else
    chk("pfx_op_imme", 32'(bus_if.imme), 32'h0034);
`endif
    // Wide sign-extension must not leak into the next op (state back to IDLE).
    drive(1'b1, 4'h3, 4'h4, 2'b00);
    step();
    chk("after_pfx_imme", 32'(bus_if.imme), 32'h0034);
    drive(1'b0, 4'h0, 4'h0, 2'b00);
    step();

    // Backpressure: first result held, second offer stalled, then both go.
    bus_if.out_ready = 1'b0;
    drive(1'b1, 4'hF, 4'h6, 2'b01);
    step();
    chk("bp_first_imme", 32'(bus_if.imme), 32'h00F6);
    drive(1'b1, 4'h1, 4'h2, 2'b00);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_in_ready_%0d", c), 32'(bus_if.in_ready), 32'd0);
      step();
      chk($sformatf("bp_hold_valid_%0d", c), 32'(bus_if.out_valid), 32'd1);
      chk($sformatf("bp_hold_imme_%0d", c), 32'(bus_if.imme), 32'h00F6);
    end
    bus_if.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(bus_if.in_ready), 32'd1);
    step();
    chk("bp_second_valid", 32'(bus_if.out_valid), 32'd1);
    chk("bp_second_imme", 32'(bus_if.imme), 32'h0012);
    drive(1'b0, 4'h0, 4'h0, 2'b00);
    step();
    chk("bp_drained", 32'(bus_if.out_valid), 32'd0);

    // Double prefix.
    drive(1'b1, 4'h1, 4'h2, 2'b11);
    step();
    chk("dpfx_first_err", 32'(bus_if.err), 32'd`ifdef IMM_EXTEND_PREFIX_EN 0 `else 1 `endif);
    drive(1'b1, 4'h5, 4'h6, 2'b11);
    step();
    chk("dpfx_second_err", 32'(bus_if.err), 32'd1);
    drive(1'b1, 4'h7, 4'h8, 2'b01);
    step();
    chk("dpfx_final_err", 32'(bus_if.err), 32'd0);
    chk("dpfx_final_valid", 32'(bus_if.out_valid), 32'd1);
`ifdef IMM_EXTEND_PREFIX_EN
    chk("dpfx_final_imme", 32'(bus_if.imme), 32'h5678);
`else
    chk("dpfx_final_imme", 32'(bus_if.imme), 32'h0078);
`endif
    drive(1'b0, 4'h0, 4'h0, 2'b00);
    step();

    // Reset discards a pending prefix and overrides a simultaneous transfer.
    drive(1'b1, 4'h1, 4'h2, 2'b11);
    step();
    rst_n = 1'b0;
    drive(1'b1, 4'h3, 4'h4, 2'b01);
    step();
    chk("rst_mid_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rst_mid_imme", 32'(bus_if.imme), 32'h0);
    chk("rst_mid_err", 32'(bus_if.err), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 4'h8, 4'h0, 2'b00);
    step();
    chk("rst_after_valid", 32'(bus_if.out_valid), 32'd1);
    chk("rst_after_imme", 32'(bus_if.imme), 32'hFF80);
    drive(1'b0, 4'h0, 4'h0, 2'b00);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
